t_skew_acc: RTL and testbench
=============================

Name: t_skew_acc

Overview:
Multi-channel post-processor for delay-line skew TDCs. It takes already-sampled thermometer snapshots, STAGES+1 bits per channel, and decodes each one with a selectable decode mode. For each channel in turn, it accumulates 2^AVG_LOG2 valid samples and reports mean, min, max and a sticky bubble flag over a valid/ready result interface. It sits between the per-channel delay-chain samplers and the readout/register block, all in the single system clock domain.

Parameters:
STAGES, 64, delay stages per channel; thermometer word is STAGES+1 bits; CW = $clog2(STAGES+1).
CHANNELS, 4, channel count; must be >= 2; CHW = $clog2(CHANNELS).
AVG_LOG2, 4, log2 of the number of samples accumulated per channel; 0..8.
DECODE_MODE, 0, 0 = highest-set-bit index (legacy); 1 = ones-count of bits [STAGES:1] (bubble-tolerant).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to run a full sweep over all channels.
therm_in  input  CHANNELS*(STAGES+1)  concatenated snapshots; channel c occupies bits [c*(STAGES+1) +: STAGES+1].
therm_valid  input  1  therm_in holds a new snapshot this cycle.
busy  output  1  a sweep is in progress.
res_valid  output  1  result fields are valid.
res_ready  input  1  consumer accepts the result.
res_ch  output  CHW  channel index of the result.
res_mean  output  CW  mean code: sum >> AVG_LOG2, truncated.
res_min  output  CW  minimum code seen in the window.
res_max  output  CW  maximum code seen in the window.
res_bubble  output  1  at least one sample in the window had a bubble.

Behaviour:
- Reset, asynchronous: FSM=IDLE; busy, res_valid, res_bubble = 0; res_ch, res_mean, res_min, res_max = 0; accumulator, sample counter and channel index cleared. Reset asserted mid-sweep aborts the sweep; no partial result is emitted.
- Decode is combinational on the selected channel word w:
  - mode 0: code = highest k with w[k]=1, else 0.
  - mode 1: code = popcount(w[STAGES:1]).
  - Both modes give a code in 0..STAGES.
- Bubble: the number of positions k in 0..STAGES-1 where w[k] != w[k+1] is greater than 1.
- FSM IDLE:
  - start=1 -> ACCUM with ch=0, sum=0, cnt=0, min=all-ones, max=0, bub=0.
  - busy goes high the cycle after start.
- FSM ACCUM:
  - Each cycle with therm_valid=1: sum += code (width CW+AVG_LOG2, cannot overflow), min/max updated, bub |= bubble, cnt++.
  - therm_valid=0 cycles are ignored.
  - The sample that makes cnt = 2^AVG_LOG2 is included; next state is REPORT.
- FSM REPORT:
  - res_valid=1 starting the cycle after the last sample (1-cycle latency).
  - res_ch=ch; res_mean=sum[CW+AVG_LOG2-1:AVG_LOG2]; res_min, res_max, res_bubble from the window.
  - All fields stay stable while res_valid && !res_ready. therm_valid is ignored in REPORT.
  - On res_valid && res_ready: if ch == CHANNELS-1 -> IDLE (busy=0, res_valid=0 next cycle). Otherwise ch++, per-window state cleared, -> ACCUM.
  - The previous result fields hold their values after acceptance; only res_valid drops.
- start while busy is ignored. start in the same cycle as the final acceptance is ignored; a new start is required in IDLE.
- AVG_LOG2=0: single-sample window; mean = min = max = code.
- Consumer may hold res_ready=1 permanently: each result is accepted the cycle it appears, and the next channel's ACCUM starts the following cycle.

Test Plan:
1. Reset: assert rst_n=0 mid-ACCUM with res_ready=0 -> busy=0, res_valid=0, all result fields 0 immediately; after release, no result appears without start.
2. STAGES=8, CHANNELS=2, AVG_LOG2=2, mode 0: start; ch0 word 9'b000011111, ch1 word 0, 4 valid samples each, res_ready=1 -> ch0 result mean=min=max=4, bubble=0; then ch1 result 0/0/0, bubble=0; busy drops after ch1 is accepted.
3. Same config, ch0 codes 3,5,4,6 (words 0x0F, 0x3F, 0x1F, 0x7F) -> sum=18, mean=4, min=3, max=6.
4. Bubble word 9'b000101111 in ch0 window -> mode 0 code 5; mode 1 code 4; res_bubble=1 for that window only (ch1 window reports 0).
5. Backpressure: hold res_ready=0 for 10 cycles with therm_valid toggling -> res_valid stays 1, fields constant, no samples counted; raise res_ready -> ch1 ACCUM starts the next cycle.
6. Gaps and start collisions: therm_valid asserted 1-in-3 cycles -> identical results to the dense case; pulse start during ACCUM and on the final-accept cycle -> no extra sweep, busy=0 afterward.

Source files
------------

// File: rtl/t_skew_acc_if.sv
// ---------------------------------------------------------------------------
// t_skew_acc_if : result handshake bundle of the skew-TDC post-processor.
//   master (producer, the accumulator) drives res_valid and the result fields
//   and samples res_ready; slave (readout/register block) drives res_ready.
//   res_valid  : result fields are valid
//   res_ready  : consumer accepts the result
//   res_ch     : channel index of the result         (CHW bits)
//   res_mean   : truncated mean code of the window   (CW bits)
//   res_min    : minimum code seen in the window     (CW bits)
//   res_max    : maximum code seen in the window     (CW bits)
//   res_bubble : at least one sample had a bubble
// ---------------------------------------------------------------------------
interface t_skew_acc_if #(
  parameter int STAGES   = 64,
  parameter int CHANNELS = 4
);
  localparam int CW  = $clog2(STAGES + 1);
  localparam int CHW = $clog2(CHANNELS);

  logic           res_valid;
  logic           res_ready;
  logic [CHW-1:0] res_ch;
  logic [CW-1:0]  res_mean;
  logic [CW-1:0]  res_min;
  logic [CW-1:0]  res_max;
  logic           res_bubble;

  modport master (
    output res_valid, res_ch, res_mean, res_min, res_max, res_bubble,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ch, res_mean, res_min, res_max, res_bubble,
    output res_ready
  );
endinterface

// File: rtl/t_skew_acc.sv
// ---------------------------------------------------------------------------
// t_skew_acc : multi-channel post-processor for delay-line skew TDCs.
//   Decodes pre-sampled thermometer snapshots (STAGES+1 bits per channel),
//   accumulates 2^AVG_LOG2 valid samples per channel, one channel after the
//   other, and reports mean/min/max/bubble per channel over a valid/ready
//   result interface.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : one-cycle request for a sweep over all channels
//   therm_in    : concatenated snapshots, channel c at [c*(STAGES+1) +: STAGES+1]
//   therm_valid : therm_in holds a new snapshot this cycle
//   busy        : a sweep is in progress
//   res         : result handshake (t_skew_acc_if.master)
// ---------------------------------------------------------------------------
module t_skew_acc #(
  parameter int STAGES      = 64,
  parameter int CHANNELS    = 4,
  parameter int AVG_LOG2    = 4,
  parameter int DECODE_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CHANNELS*(STAGES+1)-1:0]  therm_in,
  input  logic                            therm_valid,
  output logic                            busy,
  t_skew_acc_if.master                    res
);

  localparam int W    = STAGES + 1;
  localparam int CW   = $clog2(W);
  localparam int CHW  = $clog2(CHANNELS);
  localparam int SW   = CW + AVG_LOG2;
  localparam int CNTW = AVG_LOG2 + 1;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_e;

  // Legacy decode: index of the highest set bit, 0 for an all-zero word.
  function automatic logic [CW-1:0] msb_code(input logic [W-1:0] w);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < W; k++) begin
      if (w[k]) c = CW'(k);
    end
    return c;
  endfunction

  // Bubble-tolerant decode: ones-count of bits [STAGES:1].
  function automatic logic [CW-1:0] pop_code(input logic [W-1:0] w);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 1; k < W; k++) begin
      c = c + {{(CW-1){1'b0}}, w[k]};
    end
    return c;
  endfunction

  // A clean thermometer has at most one 1->0 edge; more edges mean a bubble.
  function automatic logic has_bubble(input logic [W-1:0] w);
    int n;
    n = 0;
    for (int k = 0; k < W - 1; k++) begin
      if (w[k] != w[k+1]) n++;
    end
    return (n > 1);
  endfunction

  state_e          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   min_q, min_d;
  logic [CW-1:0]   max_q, max_d;
  logic            bub_q, bub_d;
  logic [CHW-1:0]  res_ch_q, res_ch_d;
  logic [CW-1:0]   res_mean_q, res_mean_d;
  logic [CW-1:0]   res_min_q, res_min_d;
  logic [CW-1:0]   res_max_q, res_max_d;
  logic            res_bub_q, res_bub_d;

  logic [W-1:0]    word;
  logic [CW-1:0]   code;
  logic            bubble;
  logic [SW-1:0]   sum_nx;
  logic [CW-1:0]   min_nx;
  logic [CW-1:0]   max_nx;
  logic            bub_nx;

  // ---- stage: channel select and decode (combinational) ----
  always_comb begin
    word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CHW'(c)) word = therm_in[c*W +: W];
    end
    code   = (DECODE_MODE == 1) ? pop_code(word) : msb_code(word);
    bubble = has_bubble(word);
    sum_nx = sum_q + SW'(code);
    min_nx = (code < min_q) ? code : min_q;
    max_nx = (code > max_q) ? code : max_q;
    bub_nx = bub_q | bubble;
  end

  // ---- stage: window accumulation and result hand-off ----
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    min_d      = min_q;
    max_d      = max_q;
    bub_d      = bub_q;
    res_ch_d   = res_ch_q;
    res_mean_d = res_mean_q;
    res_min_d  = res_min_q;
    res_max_d  = res_max_q;
    res_bub_d  = res_bub_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          ch_d    = '0;
          sum_d   = '0;
          cnt_d   = '0;
          min_d   = '1;
          max_d   = '0;
          bub_d   = 1'b0;
        end
      end
      S_ACCUM: begin
        if (therm_valid) begin
          sum_d = sum_nx;
          min_d = min_nx;
          max_d = max_nx;
          bub_d = bub_nx;
          cnt_d = cnt_q + 1'b1;
          // Result fields are captured with the closing sample so they are
          // valid together with the REPORT state one cycle later.
          if (cnt_q == CNT_LAST) begin
            state_d    = S_REPORT;
            res_ch_d   = ch_q;
            res_mean_d = CW'(sum_nx >> AVG_LOG2);
            res_min_d  = min_nx;
            res_max_d  = max_nx;
            res_bub_d  = bub_nx;
          end
        end
      end
      S_REPORT: begin
        if (res.res_ready) begin
          if (ch_q == CH_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ACCUM;
            ch_d    = ch_q + 1'b1;
            sum_d   = '0;
            cnt_d   = '0;
            min_d   = '1;
            max_d   = '0;
            bub_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      bub_q      <= 1'b0;
      res_ch_q   <= '0;
      res_mean_q <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
      res_bub_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      min_q      <= min_d;
      max_q      <= max_d;
      bub_q      <= bub_d;
      res_ch_q   <= res_ch_d;
      res_mean_q <= res_mean_d;
      res_min_q  <= res_min_d;
      res_max_q  <= res_max_d;
      res_bub_q  <= res_bub_d;
    end
  end

  // ---- stage: outputs ----
  assign busy           = (state_q != S_IDLE);
  assign res.res_valid  = (state_q == S_REPORT);
  assign res.res_ch     = res_ch_q;
  assign res.res_mean   = res_mean_q;
  assign res.res_min    = res_min_q;
  assign res.res_max    = res_max_q;
  assign res.res_bubble = res_bub_q;

endmodule

// File: tb/tb_t_skew_acc.sv
// ---------------------------------------------------------------------------
// tb_t_skew_acc : two instances (mode 0 and mode 1) share stimulus; results
// are compared with a reference model computed from the decoding rules.
// Result tuple layout: {valid, ch, mean[3:0], min[3:0], max[3:0], bubble}.
// ---------------------------------------------------------------------------
module tb_t_skew_acc;
  localparam int STAGES   = 8;
  localparam int CHANNELS = 2;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 4;
  localparam int W        = STAGES + 1;
  localparam int TW       = CHANNELS * W;
  localparam int CW       = 4;
  localparam int CHW      = 1;
  localparam int RW       = 1 + CHW + 3 * CW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TW-1:0] therm_in;
  logic          therm_valid;
  logic          res_ready;
  logic          busy0, busy1;

  t_skew_acc_if #(.STAGES(STAGES), .CHANNELS(CHANNELS)) ifc0 ();
  t_skew_acc_if #(.STAGES(STAGES), .CHANNELS(CHANNELS)) ifc1 ();
  assign ifc0.res_ready = res_ready;
  assign ifc1.res_ready = res_ready;

  t_skew_acc #(.STAGES(STAGES), .CHANNELS(CHANNELS), .AVG_LOG2(AVG_LOG2), .DECODE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .therm_in(therm_in),
    .therm_valid(therm_valid), .busy(busy0), .res(ifc0)
  );
  t_skew_acc #(.STAGES(STAGES), .CHANNELS(CHANNELS), .AVG_LOG2(AVG_LOG2), .DECODE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .therm_in(therm_in),
    .therm_valid(therm_valid), .busy(busy1), .res(ifc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  win   [CHANNELS][NS];
  logic [RW-1:0] o_res [2][CHANNELS];
  logic [RW-1:0] keep  [2][CHANNELS];
  int            o_early, o_busy_bad;
  bit            o_stable, o_after_ok, o_hold;

  // ---------------- reference model ----------------
  function automatic int code_of(input int mode, input logic [W-1:0] w);
    int v, c;
    if (mode == 1) return $countones(w >> 1);
    v = int'(w);
    c = 0;
    while (v > 1) begin
      v = v >> 1;
      c++;
    end
    return c;
  endfunction

  function automatic bit bubble_of(input logic [W-1:0] w);
    logic [W-1:0] t;
    t = w ^ (w >> 1);
    t[W-1] = 1'b0;
    return $countones(t) > 1;
  endfunction

  function automatic logic [RW-1:0] exp_tuple(input int mode, input int ch);
    int sum, mn, mx, c;
    bit b;
    sum = 0; mn = 1000; mx = 0; b = 1'b0;
    for (int s = 0; s < NS; s++) begin
      c   = code_of(mode, win[ch][s]);
      sum = sum + c;
      if (c < mn) mn = c;
      if (c > mx) mx = c;
      b = b | bubble_of(win[ch][s]);
    end
    return {1'b1, CHW'(ch), CW'(sum / NS), CW'(mn), CW'(mx), b};
  endfunction

  // ---------------- observation and stimulus helpers ----------------
  function automatic logic [RW-1:0] tuple(input int d);
    if (d == 0)
      return {ifc0.res_valid, ifc0.res_ch, ifc0.res_mean, ifc0.res_min, ifc0.res_max, ifc0.res_bubble};
    return {ifc1.res_valid, ifc1.res_ch, ifc1.res_mean, ifc1.res_min, ifc1.res_max, ifc1.res_bubble};
  endfunction

  function automatic logic [W-1:0] rand_word();
    if ($urandom_range(0, 2) == 0) return W'($urandom);
    return W'((1 << $urandom_range(0, W)) - 1);
  endfunction

  task automatic fill_random();
    for (int c = 0; c < CHANNELS; c++)
      for (int s = 0; s < NS; s++) win[c][s] = rand_word();
  endtask

  // Drives one full sweep and records what the two instances present.
  task automatic sweep(input int gap, input int bp, input bit collide);
    logic [RW-1:0] t0, t1;
    o_early = 0; o_busy_bad = 0; o_stable = 1'b1; o_after_ok = 1'b1; o_hold = 1'b1;
    res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int s = 0; s < NS; s++) begin
        for (int g = 0; g < gap; g++) begin
          if (ifc0.res_valid || ifc1.res_valid) o_early++;
          if (!busy0 || !busy1) o_busy_bad++;
          therm_valid = 1'b0;
          therm_in    = TW'($urandom);
          if (collide && c == 0 && s == 1) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        if (ifc0.res_valid || ifc1.res_valid) o_early++;
        if (!busy0 || !busy1) o_busy_bad++;
        therm_in = TW'($urandom);
        therm_in[c*W +: W] = win[c][s];
        therm_valid = 1'b1;
        @(negedge clk);
      end
      therm_valid = 1'b0;
      therm_in    = TW'($urandom);
      o_res[0][c] = tuple(0);
      o_res[1][c] = tuple(1);
      if (bp > 0) begin
        res_ready = 1'b0;
        for (int b = 0; b < bp; b++) begin
          therm_valid = 1'($urandom);
          therm_in    = TW'($urandom);
          @(negedge clk);
          if (tuple(0) !== o_res[0][c] || tuple(1) !== o_res[1][c]) o_stable = 1'b0;
        end
        therm_valid = 1'b0;
        res_ready   = 1'b1;
      end
      if (collide && c == CHANNELS - 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (ifc0.res_valid || ifc1.res_valid) o_after_ok = 1'b0;
      if (busy0 !== (c != CHANNELS - 1) || busy1 !== (c != CHANNELS - 1)) o_after_ok = 1'b0;
      t0 = tuple(0);
      t1 = tuple(1);
      if (t0[RW-2:0] !== o_res[0][c][RW-2:0] || t1[RW-2:0] !== o_res[1][c][RW-2:0]) o_hold = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      therm_valid = 1'($urandom);
      @(negedge clk);
      if (busy0 || busy1 || ifc0.res_valid || ifc1.res_valid) o_after_ok = 1'b0;
    end
    therm_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b/%b expected 0/0", busy0, busy1);
    end
    n_checks++;
    if (tuple(0) !== '0 || tuple(1) !== '0) begin
      n_fail++; $display("FAIL reset_fields got %h/%h expected 0/0", tuple(0), tuple(1));
    end
  endtask

  task automatic test_dense();
    for (int s = 0; s < NS; s++) begin
      win[0][s] = 9'b000011111;
      win[1][s] = 9'b000000000;
    end
    sweep(0, 0, 1'b0);
    n_checks++;
    if (o_res[0][0] !== {1'b1, 1'b0, 4'd4, 4'd4, 4'd4, 1'b0}) begin
      n_fail++; $display("FAIL dense_ch0 got %h expected %h", o_res[0][0], {1'b1, 1'b0, 4'd4, 4'd4, 4'd4, 1'b0});
    end
    n_checks++;
    if (o_res[0][1] !== {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL dense_ch1 got %h expected %h", o_res[0][1], {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0});
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CHANNELS; c++) begin
        n_checks++;
        if (o_res[d][c] !== exp_tuple(d, c)) begin
          n_fail++; $display("FAIL dense_model d%0d ch%0d got %h expected %h", d, c, o_res[d][c], exp_tuple(d, c));
        end
      end
    n_checks++;
    if (o_early != 0 || o_busy_bad != 0) begin
      n_fail++; $display("FAIL dense_protocol early_valid=%0d busy_low=%0d expected 0/0", o_early, o_busy_bad);
    end
    n_checks++;
    if (!o_after_ok || !o_hold) begin
      n_fail++; $display("FAIL dense_after_accept after_ok=%0b hold=%0b expected 1/1", o_after_ok, o_hold);
    end
  endtask

  task automatic test_codes();
    win[0][0] = 9'h00F; win[0][1] = 9'h03F; win[0][2] = 9'h01F; win[0][3] = 9'h07F;
    for (int s = 0; s < NS; s++) win[1][s] = W'((1 << $urandom_range(0, W)) - 1);
    sweep(0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_res[d][0] !== {1'b1, 1'b0, 4'd4, 4'd3, 4'd6, 1'b0}) begin
        n_fail++; $display("FAIL codes_ch0 d%0d got %h expected %h", d, o_res[d][0], {1'b1, 1'b0, 4'd4, 4'd3, 4'd6, 1'b0});
      end
      n_checks++;
      if (o_res[d][1] !== exp_tuple(d, 1)) begin
        n_fail++; $display("FAIL codes_ch1 d%0d got %h expected %h", d, o_res[d][1], exp_tuple(d, 1));
      end
    end
  endtask

  task automatic test_bubble();
    for (int s = 0; s < NS; s++) begin
      win[0][s] = 9'b000011111;
      win[1][s] = W'((1 << $urandom_range(0, W)) - 1);
    end
    win[0][2] = 9'b000101111;
    sweep(0, 0, 1'b0);
    n_checks++;
    if (o_res[0][0] !== {1'b1, 1'b0, 4'd4, 4'd4, 4'd5, 1'b1}) begin
      n_fail++; $display("FAIL bubble_mode0 got %h expected %h", o_res[0][0], {1'b1, 1'b0, 4'd4, 4'd4, 4'd5, 1'b1});
    end
    n_checks++;
    if (o_res[1][0] !== {1'b1, 1'b0, 4'd4, 4'd4, 4'd4, 1'b1}) begin
      n_fail++; $display("FAIL bubble_mode1 got %h expected %h", o_res[1][0], {1'b1, 1'b0, 4'd4, 4'd4, 4'd4, 1'b1});
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_res[d][1] !== exp_tuple(d, 1) || o_res[d][1][0] !== 1'b0) begin
        n_fail++; $display("FAIL bubble_ch1_clean d%0d got %h expected %h", d, o_res[d][1], exp_tuple(d, 1));
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    sweep(0, 10, 1'b0);
    n_checks++;
    if (!o_stable) begin
      n_fail++; $display("FAIL backpressure_stable got 0 expected 1");
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CHANNELS; c++) begin
        n_checks++;
        if (o_res[d][c] !== exp_tuple(d, c)) begin
          n_fail++; $display("FAIL backpressure_result d%0d ch%0d got %h expected %h", d, c, o_res[d][c], exp_tuple(d, c));
        end
      end
    n_checks++;
    if (o_early != 0 || !o_after_ok) begin
      n_fail++; $display("FAIL backpressure_protocol early=%0d after_ok=%0b expected 0/1", o_early, o_after_ok);
    end
  endtask

  task automatic test_gaps();
    fill_random();
    sweep(0, 0, 1'b0);
    keep = o_res;
    sweep(2, 0, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CHANNELS; c++) begin
        n_checks++;
        if (o_res[d][c] !== keep[d][c] || o_res[d][c] !== exp_tuple(d, c)) begin
          n_fail++; $display("FAIL gaps d%0d ch%0d got %h dense %h expected %h", d, c, o_res[d][c], keep[d][c], exp_tuple(d, c));
        end
      end
    n_checks++;
    if (o_early != 0 || o_busy_bad != 0) begin
      n_fail++; $display("FAIL gaps_protocol early=%0d busy_low=%0d expected 0/0", o_early, o_busy_bad);
    end
  endtask

  task automatic test_start_collision();
    fill_random();
    sweep(1, 0, 1'b1);
    n_checks++;
    if (!o_after_ok) begin
      n_fail++; $display("FAIL start_collision_idle got after_ok=0 expected 1");
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CHANNELS; c++) begin
        n_checks++;
        if (o_res[d][c] !== exp_tuple(d, c)) begin
          n_fail++; $display("FAIL start_collision_result d%0d ch%0d got %h expected %h", d, c, o_res[d][c], exp_tuple(d, c));
        end
      end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    res_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      therm_in = TW'($urandom);
      therm_valid = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_busy got %b/%b expected 0/0", busy0, busy1);
    end
    n_checks++;
    if (tuple(0) !== '0 || tuple(1) !== '0) begin
      n_fail++; $display("FAIL reset_mid_fields got %h/%h expected 0/0", tuple(0), tuple(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      therm_valid = 1'b1;
      therm_in = TW'($urandom);
      @(negedge clk);
      if (busy0 || busy1 || ifc0.res_valid || ifc1.res_valid) quiet = 1'b0;
    end
    therm_valid = 1'b0;
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL reset_mid_no_start got activity expected idle");
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      fill_random();
      sweep($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < CHANNELS; c++) begin
          n_checks++;
          if (o_res[d][c] !== exp_tuple(d, c)) begin
            n_fail++; $display("FAIL random it%0d d%0d ch%0d got %h expected %h", it, d, c, o_res[d][c], exp_tuple(d, c));
          end
        end
      n_checks++;
      if (o_early != 0 || o_busy_bad != 0 || !o_stable || !o_after_ok || !o_hold) begin
        n_fail++; $display("FAIL random_protocol it%0d early=%0d busy_low=%0d stable=%0b after=%0b hold=%0b",
                           it, o_early, o_busy_bad, o_stable, o_after_ok, o_hold);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; therm_valid = 1'b0; res_ready = 1'b1; therm_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_dense();
    test_codes();
    test_bubble();
    test_backpressure();
    test_gaps();
    test_start_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
